test_status_dev: RTL
====================

Name: test_status_dev

Overview:
- Synthesizable memory-mapped test-status peripheral on the microISA-16 data bus. It is the DUT-side endpoint of the testbench logging and watchdog flow.
- Firmware uses it to:
  - stream log characters out to the bench;
  - report a final status level (INFO/ERROR/FATAL/SUCCESS);
  - run a hardware watchdog that firmware must kick.
- The bench consumes the character stream and the done/level/expired outputs, and maps them onto its logging and finish calls.

Parameters:
- FIFO_DEPTH, 8, character FIFO entries; power of two, at least 2.
- WDOG_W, 16, watchdog counter width in bits.
- WDOG_RESET_LOAD, 0, watchdog load value after reset; 0 = watchdog disabled.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  bus request valid.
- req_ready  out  1  bus request accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  3  word offset of the register.
- req_wdata  in  16  write data.
- rsp_valid  out  1  read response valid.
- rsp_rdata  out  16  read response data.
- char_valid  out  1  a character is available to the bench.
- char_ready  in  1  bench accepts the character.
- char_data  out  8  character byte.
- done  out  1  firmware has reported a final status.
- level  out  2  reported level, level_t encoding.
- wdog_expired  out  1  watchdog reached zero (sticky).

Behaviour:
- Reset (async assert) forces:
  - req_ready=1, rsp_valid=0, rsp_rdata=0;
  - char FIFO empty, so char_valid=0 and char_data=0;
  - done=0, level=INFO, wdog_expired=0;
  - wdog load=WDOG_RESET_LOAD, wdog count=WDOG_RESET_LOAD;
  - FSM state = WD_OFF if WDOG_RESET_LOAD==0, else WD_RUN.
- A transfer happens when req_valid && req_ready.
- req_ready=0 only when req_valid, req_we, req_addr==0 and the FIFO is full. The request stalls until an entry frees. A same-cycle pop frees the entry, so req_ready=1 in that cycle.
- Reads: rsp_valid=1 exactly one cycle after the accepted read, carrying rsp_rdata; rsp_valid=0 otherwise. Reads never stall.
- Register map (writes / reads):
  - 0 CHAR: write pushes wdata[7:0] into the FIFO. Read returns the FIFO occupancy, zero-extended.
  - 1 STATUS: write sets level=wdata[1:0] and done=1. Read returns {13'b0, done, level}. Once done=1, further STATUS writes are ignored until reset.
  - 2 KICK: write (any data) reloads count from load. Read returns 0.
  - 3 WLOAD: write sets load=wdata[WDOG_W-1:0] and count=same value. Read returns load.
  - 4 WCOUNT: read-only current count; writes are ignored.
  - 5-7: reads return 0; writes are ignored.
- Char stream:
  - char_valid = FIFO not empty; char_data = head entry.
  - A pop occurs on char_valid && char_ready.
  - Simultaneous push and pop when full: the push is accepted and occupancy is unchanged.
  - Simultaneous push and pop when empty: the pushed byte is not visible until the next cycle (no bypass).
- Watchdog FSM:
  - WD_OFF: count frozen. WLOAD with nonzero value -> WD_RUN.
  - WD_RUN: count decrements by 1 each cycle.
    - KICK reloads count to load.
    - WLOAD of 0 -> WD_OFF.
    - WLOAD of nonzero reloads count and stays in WD_RUN.
    - Reaching 0 while in WD_RUN -> WD_EXPIRED. wdog_expired=1 from the cycle count becomes 0.
    - A KICK in the same cycle count would become 0 wins: reload, no expiry.
  - WD_EXPIRED: sticky until reset; KICK and WLOAD are ignored. done is not forced.
  - done=1 freezes the watchdog (treated as WD_OFF) so a finished test cannot expire.
- Expiry fires exactly `load` cycles after the last reload.
- Arithmetic: the watchdog count never wraps below 0. FIFO pointers are log2(FIFO_DEPTH) bits plus one wrap bit.

Decomposition:
- Shared package `dbg_pkg` holds:
  - level_t (INFO=0, ERROR=1, FATAL=2, SUCCESS=3), shared with the testbench package;
  - register offset constants REG_CHAR..REG_WCOUNT;
  - wd_state_t enum {WD_OFF, WD_RUN, WD_EXPIRED}.
- One sub-module, `dbg_char_fifo`: a synchronous valid/ready FIFO parameterised by depth and width, exporting occupancy.

Test Plan:
- Write CHAR 0x48, then 0x69, with char_ready=1 -> char_data sequence 0x48, 0x69; each byte presented one cycle after its write; a CHAR read afterwards returns 0.
- Hold char_ready=0 and issue 9 CHAR writes (FIFO_DEPTH=8) -> 9th write sees req_ready=0. Raise char_ready for one cycle -> 9th write accepted that cycle; occupancy reads 8.
- Write STATUS 0x0003 -> done=1, level=SUCCESS next cycle. Then write STATUS 0x0001 -> level stays 3; STATUS read returns 0x0007.
- WLOAD 10 with no kicks -> wdog_expired rises 10 cycles later. A later KICK and WLOAD 5 leave it at 1.
- WLOAD 10, KICK every 8 cycles for 50 cycles -> no expiry. A KICK in the cycle count reaches 0 -> no expiry. WLOAD 0 -> WCOUNT frozen.
- Assert rst mid-stream with 3 FIFO entries, done=1 and WD_RUN -> asynchronously char_valid=0, done=0, level=0, wdog_expired=0, rsp_valid=0.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and register map for the test-status peripheral and its bench.
package dbg_pkg;

  // Final status level reported by firmware.
  typedef enum logic [1:0] {
    INFO    = 2'd0,
    ERROR   = 2'd1,
    FATAL   = 2'd2,
    SUCCESS = 2'd3
  } level_t;

  // Watchdog states. Anything outside these falls back to WD_OFF.
  typedef enum logic [1:0] {
    WD_OFF,
    WD_RUN,
    WD_EXPIRED
  } wd_state_t;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int CHAR_W = 8;

  // Word offsets of the registers. Offsets 5-7 are unmapped.
  localparam logic [ADDR_W-1:0] REG_CHAR   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd1;
  localparam logic [ADDR_W-1:0] REG_KICK   = 3'd2;
  localparam logic [ADDR_W-1:0] REG_WLOAD  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_WCOUNT = 3'd4;

endpackage

// File: rtl/test_status_dev_if.sv
// Bus, character-stream and status signals of the test-status peripheral.
// The master side is the firmware bus plus the character consumer; the slave
// side is the peripheral itself.
interface test_status_dev_if;
  import dbg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              char_valid;
  logic              char_ready;
  logic [CHAR_W-1:0] char_data;
  logic              done;
  level_t            level;
  logic              wdog_expired;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, char_ready,
    input  req_ready, rsp_valid, rsp_rdata, char_valid, char_data,
           done, level, wdog_expired
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, char_ready,
    output req_ready, rsp_valid, rsp_rdata, char_valid, char_data,
           done, level, wdog_expired
  );

endinterface

// File: rtl/dbg_char_fifo.sv
// Synchronous valid/ready FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter. A push is accepted
// while full if a pop happens in the same cycle. No read bypass: a byte pushed
// into an empty FIFO becomes visible on the following cycle.
module dbg_char_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      occupancy
);

  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_valid  = !empty;
  assign push_ready = !full || pop_ready;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;
  assign occupancy  = wr_ptr - rd_ptr;
  // Masked so the stale head entry never leaks out while the FIFO is empty.
  assign pop_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update on accepted push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_INC;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; occupancy gates every read,
  // and leaving it out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/test_status_dev.sv
// Memory-mapped test-status peripheral: character log FIFO, final status
// latch and a kickable watchdog, all behind a small valid/ready bus.
module test_status_dev
  import dbg_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 8,
  parameter int          WDOG_W          = 16,
  parameter int unsigned WDOG_RESET_LOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  test_status_dev_if.slave bus
);

  localparam int               OCC_W        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WDOG_W-1:0] WD_LOAD_RST  = WDOG_W'(WDOG_RESET_LOAD);
  localparam wd_state_t         WD_STATE_RST = (WDOG_RESET_LOAD == 0) ? WD_OFF : WD_RUN;
  localparam logic [WDOG_W-1:0] WD_ONE       = WDOG_W'(1);

  logic              char_wr;
  logic              fifo_push_ready;
  logic              xfer;
  logic              wr_en;
  logic              rd_en;
  logic [OCC_W-1:0]  occupancy;
  logic [DATA_W-1:0] rd_data;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              done_q;
  level_t            level_q;
  logic              kick_wr;
  logic              wload_wr;
  logic [WDOG_W-1:0] wload_val;
  wd_state_t         wd_state;
  wd_state_t         wd_state_nxt;
  logic [WDOG_W-1:0] wd_load;
  logic [WDOG_W-1:0] wd_load_nxt;
  logic [WDOG_W-1:0] wd_count;
  logic [WDOG_W-1:0] wd_count_nxt;

  // Only a CHAR write against a full FIFO with no pop this cycle can stall.
  assign char_wr       = bus.req_valid && bus.req_we && (bus.req_addr == REG_CHAR);
  assign bus.req_ready = !char_wr || fifo_push_ready;
  assign xfer          = bus.req_valid && bus.req_ready;
  assign wr_en         = xfer && bus.req_we;
  assign rd_en         = xfer && !bus.req_we;
  assign kick_wr       = wr_en && (bus.req_addr == REG_KICK);
  assign wload_wr      = wr_en && (bus.req_addr == REG_WLOAD);
  assign wload_val     = WDOG_W'(bus.req_wdata);

  dbg_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_char_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (char_wr),
    .push_ready (fifo_push_ready),
    .push_data  (bus.req_wdata[CHAR_W-1:0]),
    .pop_valid  (bus.char_valid),
    .pop_ready  (bus.char_ready),
    .pop_data   (bus.char_data),
    .occupancy  (occupancy)
  );

  // Read data mux, sampled from pre-edge state of the accepting cycle.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    case (bus.req_addr)
      REG_CHAR:   rd_data = DATA_W'(occupancy);
      REG_STATUS: rd_data = {13'b0, done_q, level_q};
      REG_WLOAD:  rd_data = DATA_W'(wd_load);
      REG_WCOUNT: rd_data = DATA_W'(wd_count);
      default:    rd_data = '0;
    endcase
  end

  // Read response: valid exactly one cycle after the accepted read, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      rsp_rdata_q <= rd_en ? rd_data : '0;
    end
  end

  // Final status latch: first STATUS write wins until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      level_q <= INFO;
    end else if (wr_en && (bus.req_addr == REG_STATUS) && !done_q) begin
      done_q  <= 1'b1;
      level_q <= level_t'(bus.req_wdata[1:0]);
    end
  end

  // Watchdog state, load and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_state <= WD_STATE_RST;
      wd_load  <= WD_LOAD_RST;
      wd_count <= WD_LOAD_RST;
    end else begin
      wd_state <= wd_state_nxt;
      wd_load  <= wd_load_nxt;
      wd_count <= wd_count_nxt;
    end
  end

  // Watchdog next state. A reload in the cycle the count would hit zero wins
  // over expiry; once done is set the count holds so a finished test cannot
  // expire.
  always_comb begin
    wd_state_nxt = wd_state;
    wd_load_nxt  = wd_load;
    wd_count_nxt = wd_count;
    case (wd_state)
      WD_OFF: begin
        if (wload_wr) begin
          wd_load_nxt  = wload_val;
          wd_count_nxt = wload_val;
          if (wload_val != '0) wd_state_nxt = WD_RUN;
        end
      end
      WD_RUN: begin
        if (wload_wr) begin
          wd_load_nxt  = wload_val;
          wd_count_nxt = wload_val;
          if (wload_val == '0) wd_state_nxt = WD_OFF;
        end else if (done_q) begin
          wd_count_nxt = wd_count;
        end else if (kick_wr) begin
          wd_count_nxt = wd_load;
        end else if (wd_count <= WD_ONE) begin
          wd_count_nxt = '0;
          wd_state_nxt = WD_EXPIRED;
        end else begin
          wd_count_nxt = wd_count - WD_ONE;
        end
      end
      WD_EXPIRED: wd_state_nxt = WD_EXPIRED;
      default:    wd_state_nxt = WD_OFF;
    endcase
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.done         = done_q;
  assign bus.level        = level_q;
  assign bus.wdog_expired = (wd_state == WD_EXPIRED);

endmodule
